// File: rtl/usage_reminder_timer.sv
// Working-time accumulator (saturating hh:mm:ss) with a latched cleaning reminder.
// Optional blink output is built only when REMINDER_BLINK_EN is defined.
//
// state   | meaning
// S_IDLE  | hood stopped, accumulation paused
// S_RUN   | hood working, accumulating time
// S_ALERT | threshold reached, reminder latched until clean_clear or rst
module usage_reminder_timer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hood_working,
    input  logic       clean_clear,
    input  logic [5:0] thr_hour,
    input  logic [5:0] thr_min,
    input  logic [5:0] thr_sec,
    output logic [5:0] acc_hour,
    output logic [5:0] acc_min,
    output logic [5:0] acc_sec,
    output logic       reminder,
    output logic       reminder_blink
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ALERT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          reminder_q;
    logic          tick;
    logic          at_max;
    logic [5:0]    thr_min_c, thr_sec_c;
    logic          thr_zero;
    logic          thr_hit;

    assign tick   = hood_working && (pre_q == PW'(CLK_HZ - 1));
    assign at_max = (hour_q == 6'd63) && (min_q == 6'd59) && (sec_q == 6'd59);

    // Clamping only lowers out-of-range values, so "zero" is the same before and after it.
    assign thr_min_c = (thr_min > 6'd59) ? 6'd59 : thr_min;
    assign thr_sec_c = (thr_sec > 6'd59) ? 6'd59 : thr_sec;
    assign thr_zero  = (thr_hour == 6'd0) && (thr_min_c == 6'd0) && (thr_sec_c == 6'd0);
    assign thr_hit   = !thr_zero &&
                       ({hour_q, min_q, sec_q} >= {thr_hour, thr_min_c, thr_sec_c});

    always_comb begin
        pre_d = pre_q;
        if (clean_clear) begin
            pre_d = '0;
        end else if (hood_working) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (clean_clear) begin
            hour_d = '0;
            min_d  = '0;
            sec_d  = '0;
        end else if (tick && !at_max) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d  = '0;
                    hour_d = hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // The threshold is checked from IDLE too, so the reminder always rises one cycle after the hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (thr_hit)           state_d = S_ALERT;
                else if (hood_working) state_d = S_RUN;
            end
            S_RUN: begin
                if (thr_hit)            state_d = S_ALERT;
                else if (!hood_working) state_d = S_IDLE;
            end
            S_ALERT: state_d = S_ALERT;
            default: state_d = S_IDLE;
        endcase
        if (clean_clear) begin
            state_d = hood_working ? S_RUN : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            reminder_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            reminder_q <= (state_d == S_ALERT);
        end
    end

    assign acc_hour = hour_q;
    assign acc_min  = min_q;
    assign acc_sec  = sec_q;
    assign reminder = reminder_q;

`ifdef REMINDER_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    logic          rem_rise;

    assign rem_rise = (state_d == S_ALERT) && !reminder_q;

    // Restarting on the rising reminder makes the first half-period lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (rem_rise) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign reminder_blink = reminder_q & phase_q;
`else
    logic [31:0] blink_div_unused;
    assign blink_div_unused = 32'(BLINK_DIV);
    assign reminder_blink   = reminder_q;
`endif

endmodule
